// File: rtl/fnd_scan_ctrl_if.sv
// Signal bundle between the stopwatch datapath/display pins and the FND scan controller.
// The master side drives time values and reads the display pins. The slave side is the scan controller.
interface fnd_scan_ctrl_if;

   logic [6:0] msec;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic       sel_mode;
   logic [3:0] fnd_com;
   logic [7:0] fnd_data;

   modport master (
      output msec,
      output sec,
      output min,
      output hour,
      output sel_mode,
      input  fnd_com,
      input  fnd_data
   );

   modport slave (
      input  msec,
      input  sec,
      input  min,
      input  hour,
      input  sel_mode,
      output fnd_com,
      output fnd_data
   );

endinterface

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display showing SEC.MSEC or HOUR.MIN.
// The time inputs are frozen once per scan frame so that one frame never mixes digits from two different times.
module fnd_scan_ctrl #(
   parameter int SCAN_COUNT   = 100_000,
   parameter int BLINK_THRESH = 50
) (
   input  logic            clk,
   input  logic            reset,
   fnd_scan_ctrl_if.slave  bus
);

   localparam int            CW       = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_COUNT - 1);

   logic [CW-1:0] scanCnt_q, scanCnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [6:0]    snapMsec_q;
   logic [5:0]    snapSec_q;
   logic [5:0]    snapMin_q;
   logic [4:0]    snapHour_q;
   logic          snapMode_q;
   logic [3:0]    fndCom_q, fndCom_d;
   logic [7:0]    fndData_q, fndData_d;

   logic          scanTick;
   logic          frameEnd;
   logic [6:0]    digit;
   logic          dpLit;

   // Active-low gfedcba pattern. Any value outside 0..9 is shown as a blank digit.
   function automatic logic [6:0] seg7(input logic [6:0] value);
      logic [6:0] pattern;
      case (value)
         7'd0:    pattern = 7'h40;
         7'd1:    pattern = 7'h79;
         7'd2:    pattern = 7'h24;
         7'd3:    pattern = 7'h30;
         7'd4:    pattern = 7'h19;
         7'd5:    pattern = 7'h12;
         7'd6:    pattern = 7'h02;
         7'd7:    pattern = 7'h78;
         7'd8:    pattern = 7'h00;
         7'd9:    pattern = 7'h10;
         default: pattern = 7'h7F;
      endcase
      return pattern;
   endfunction

   always_comb begin
      scanTick  = (scanCnt_q == CNT_LAST);
      frameEnd  = scanTick && (idx_q == 2'd3);
      scanCnt_d = scanTick ? '0 : scanCnt_q + 1'b1;
      idx_d     = scanTick ? idx_q + 2'd1 : idx_q;
   end

   // Digit contents come only from the snapshot. The divide and modulo are combinational ahead of the output register.
   always_comb begin
      digit = 7'd0;
      case ({snapMode_q, idx_q})
         3'b0_00: digit = snapMsec_q % 7'd10;
         3'b0_01: digit = snapMsec_q / 7'd10;
         3'b0_10: digit = {1'b0, snapSec_q} % 7'd10;
         3'b0_11: digit = {1'b0, snapSec_q} / 7'd10;
         3'b1_00: digit = {1'b0, snapMin_q} % 7'd10;
         3'b1_01: digit = {1'b0, snapMin_q} / 7'd10;
         3'b1_10: digit = {2'b00, snapHour_q} % 7'd10;
         3'b1_11: digit = {2'b00, snapHour_q} / 7'd10;
         default: digit = 7'd0;
      endcase
   end

   // The separator dot sits on digit 2 in both views. It blinks with the snapshot msec.
   always_comb begin
      dpLit     = (idx_q == 2'd2) && (int'(snapMsec_q) < BLINK_THRESH);
      fndCom_d  = ~(4'b0001 << idx_q);
      fndData_d = {~dpLit, seg7(digit)};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scanCnt_q  <= '0;
         idx_q      <= 2'd0;
         snapMsec_q <= 7'd0;
         snapSec_q  <= 6'd0;
         snapMin_q  <= 6'd0;
         snapHour_q <= 5'd0;
         snapMode_q <= 1'b0;
         fndCom_q   <= 4'b1111;
         fndData_q  <= 8'hFF;
      end else begin
         scanCnt_q <= scanCnt_d;
         idx_q     <= idx_d;
         if (frameEnd) begin
            snapMsec_q <= bus.msec;
            snapSec_q  <= bus.sec;
            snapMin_q  <= bus.min;
            snapHour_q <= bus.hour;
            snapMode_q <= bus.sel_mode;
         end
         // Enable and segments share one register stage so that they always switch together.
         fndCom_q  <= fndCom_d;
         fndData_q <= fndData_d;
      end
   end

   assign bus.fnd_com  = fndCom_q;
   assign bus.fnd_data = fndData_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl with SCAN_COUNT=4. Expectations are tagged with the clock edge
// (counted from reset release) at which they must be visible. The tag -1 marks a check made right after reset assertion.
module tb_fnd_scan_ctrl;

   typedef struct {
      int         tag;
      logic [3:0] com;
      logic [7:0] data;
      string      name;
   } expT;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   edgeN = 0;
   int   vectors = 0;
   int   miscompares = 0;
   expT  expQ[$];

   fnd_scan_ctrl_if busIf ();

   fnd_scan_ctrl #(
      .SCAN_COUNT   (4),
      .BLINK_THRESH (50)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (busIf)
   );

   always #5 clk = ~clk;

   // Counts rising edges since the most recent reset release. Edge 1 is the first edge after release.
   always @(posedge clk or negedge reset) begin
      if (!reset) edgeN <= 0;
      else        edgeN <= edgeN + 1;
   end

   task automatic applyStimulus(input int ms, input int s, input int m, input int h, input bit mode);
      busIf.msec     = 7'(ms);
      busIf.sec      = 6'(s);
      busIf.min      = 6'(m);
      busIf.hour     = 5'(h);
      busIf.sel_mode = mode;
   endtask

   task automatic pushExpect(input int tag, input logic [3:0] com, input logic [7:0] data, input string name);
      expT e;
      e.tag  = tag;
      e.com  = com;
      e.data = data;
      e.name = name;
      expQ.push_back(e);
   endtask

   // Queues one frame of expectations. When full is set, all four edges of every slot are checked.
   task automatic pushFrame(input int firstEdge, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3, input bit full, input string name);
      logic [3:0] comTab [4];
      logic [7:0] dataTab [4];
      comTab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      dataTab = '{d0, d1, d2, d3};
      for (int s = 0; s < 4; s++)
         for (int e = 0; e < (full ? 4 : 1); e++)
            pushExpect(firstEdge + 4 * s + e, comTab[s], dataTab[s], $sformatf("%s_d%0d_e%0d", name, s, e));
   endtask

   task automatic checkOutput(input expT e);
      vectors++;
      if (busIf.fnd_com !== e.com || busIf.fnd_data !== e.data) begin
         miscompares++;
         $display("[TB] FAIL %s: got com=%b data=%h, expected com=%b data=%h",
                  e.name, busIf.fnd_com, busIf.fnd_data, e.com, e.data);
      end
   endtask

   task automatic waitEdge(input int n);
      int guard = 0;
      while (edgeN < n && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (edgeN < n) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL wait_edge_%0d: got edge %0d, expected edge %0d", n, edgeN, n);
      end
   endtask

   // The clock-side monitor compares the head entry once its edge has been reached. It reports entries that were skipped.
   always @(negedge clk) begin
      while (expQ.size() > 0 && expQ[0].tag >= 0 && expQ[0].tag < edgeN) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s: got no check at edge %0d (now %0d), expected one", expQ[0].name, expQ[0].tag, edgeN);
         void'(expQ.pop_front());
      end
      if (expQ.size() > 0 && expQ[0].tag >= 0 && expQ[0].tag == edgeN) begin
         checkOutput(expQ[0]);
         void'(expQ.pop_front());
      end
   end

   // The reset-side monitor checks the outputs shortly after reset falls, before any clock edge can arrive.
   always @(negedge reset) begin
      #1;
      if (expQ.size() > 0 && expQ[0].tag == -1) begin
         checkOutput(expQ[0]);
         void'(expQ.pop_front());
      end
   end

   initial begin
      applyStimulus(0, 0, 0, 0, 1'b0);

      // Reset is asserted between clock edges. The outputs go dark and stay dark while reset is held.
      pushExpect(-1, 4'b1111, 8'hFF, "rst_async");
      pushExpect(0, 4'b1111, 8'hFF, "rst_held");
      #7 reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Frame 0 shows the zeroed snapshot, with the dot lit because 0 < 50. Frame 1 shows 42.37.
      pushFrame(1,  8'hC0, 8'hC0, 8'h40, 8'hC0, 1'b1, "f0_zero");
      pushFrame(17, 8'hF8, 8'hB0, 8'h24, 8'h99, 1'b1, "m0_42_37");
      applyStimulus(37, 42, 0, 0, 1'b0);

      // HOUR.MIN view of 23:05. msec 75 keeps the dot dark.
      waitEdge(17);
      pushFrame(33, 8'h92, 8'hC0, 8'hB0, 8'hA4, 1'b0, "m1_23_05");
      applyStimulus(75, 42, 5, 23, 1'b1);

      // sec changes from 42 to 43 while digit 1 of frame 3 is lit. The change appears only in frame 4.
      waitEdge(33);
      pushFrame(49, 8'hF8, 8'hB0, 8'h24, 8'h99, 1'b0, "iso_old");
      pushExpect(73, 4'b1011, 8'h30, "iso_new_d2");
      pushExpect(77, 4'b0111, 8'h99, "iso_new_d3");
      applyStimulus(37, 42, 5, 23, 1'b0);
      waitEdge(53);
      applyStimulus(37, 43, 5, 23, 1'b0);

      // msec 120 yields a tens digit of 12, which is shown blank. msec 120 is also not below 50, so the dot stays dark.
      waitEdge(74);
      pushExpect(81,  4'b1110, 8'hC0, "oor_d0");
      pushExpect(85,  4'b1101, 8'hFF, "oor_d1");
      pushExpect(89,  4'b1011, 8'hB0, "oor_d2");
      pushExpect(93,  4'b0111, 8'h99, "oor_d3");
      pushExpect(105, 4'b1011, 8'hB0, "mid_idx2");
      applyStimulus(120, 43, 5, 23, 1'b0);

      // Reset lands in the middle of the digit 2 slot. Scanning restarts at digit 0 with a zeroed snapshot and a full slot.
      waitEdge(105);
      @(posedge clk);
      #2;
      pushExpect(-1, 4'b1111, 8'hFF, "rst2_async");
      pushExpect(0,  4'b1111, 8'hFF, "rst2_held");
      pushExpect(1,  4'b1110, 8'hC0, "rst2_first");
      pushExpect(4,  4'b1110, 8'hC0, "rst2_slot_end");
      pushExpect(5,  4'b1101, 8'hC0, "rst2_d1");
      pushExpect(9,  4'b1011, 8'h40, "rst2_d2");
      pushExpect(13, 4'b0111, 8'hC0, "rst2_d3");
      pushExpect(17, 4'b1110, 8'hC0, "rst2_live_d0");
      pushExpect(21, 4'b1101, 8'hFF, "rst2_live_d1");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      waitEdge(21);

      for (int i = 0; i < 200 && expQ.size() > 0; i++) @(negedge clk);
      while (expQ.size() > 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s: got no check, expected one at edge %0d", expQ[0].name, expQ[0].tag);
         void'(expQ.pop_front());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
